// File: rtl/ram_readback_checker.sv
// ram_readback_checker: aligns the copy block's phase/address with RAM read-back data
// and checks every read-phase byte, reporting per-pass and cumulative results.
module ram_readback_checker #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int LAT    = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic [DATA_W-1:0] exp_data,
   output logic              check_active,
   output logic              mismatch,
   output logic              pass_done,
   output logic              pass_ok,
   output logic              pass_abort,
   output logic              fail_sticky,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              first_err_valid
);
   typedef enum logic [1:0] {SYNC, WRITE, READ, REPORT} state_t;
   state_t state, state_n;
   logic [LAT-1:0] vp, wp;
   logic [LAT-1:0][ADDR_W-1:0] ap;
   logic v_d, wr_d, last, bad, pass_err, pass_err_n;
   logic [ADDR_W-1:0] addr_d, prev_addr;
   always_ff @(posedge clk) begin
      vp[0] <= !rst;
      wp[0] <= wr_en;
      ap[0] <= addr;
      for (int i = 1; i < LAT; i++) begin
         vp[i] <= vp[i-1] && !rst;
         wp[i] <= wp[i-1];
         ap[i] <= ap[i-1];
      end
   end
   assign v_d = vp[LAT-1];
   assign wr_d = wp[LAT-1];
   assign addr_d = ap[LAT-1];
   assign last = addr_d == ADDR_W'(DEPTH - 1);
   assign check_active = v_d && !wr_d && (state == WRITE || state == READ);
   // a break in the read-phase address sequence is scored like a data error
   assign bad = check_active && (rd_data != exp_data || (state == READ && addr_d != prev_addr + 1'b1));
   assign pass_err_n = (state == READ && pass_err) || bad;
   assign pass_done = state == REPORT;
   assign pass_abort = state == READ && v_d && wr_d;
   always_comb begin
      state_n = state;
      case (state)
         SYNC:        state_n = v_d && wr_d && addr_d == '0 ? WRITE : SYNC;
         WRITE, READ: state_n = pass_abort ? WRITE : check_active ? (last ? REPORT : READ) : state;
         REPORT:      state_n = v_d && wr_d ? WRITE : SYNC;
         default:     state_n = SYNC;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SYNC;
         mismatch <= 1'b0;
         pass_ok <= 1'b0;
         fail_sticky <= 1'b0;
         err_cnt <= '0;
         pass_cnt <= '0;
         first_err_addr <= '0;
         first_err_valid <= 1'b0;
         pass_err <= 1'b0;
         prev_addr <= '0;
      end else begin
         state <= state_n;
         mismatch <= bad;
         if (bad) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            fail_sticky <= 1'b1;
            if (!first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_addr <= addr_d;
            end
         end
         if (check_active) begin
            prev_addr <= addr_d;
            pass_err <= pass_err_n;
         end
         if (check_active && last) begin
            pass_ok <= !pass_err_n;
            pass_cnt <= pass_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ram_readback_checker.sv
// tb_ram_readback_checker: scenario table plus randomized passes against a pass-level model,
// run on two instances (LAT=1 and LAT=3 with narrow counters) fed the same address stream.
module tb_ram_readback_checker;
   localparam int DEPTH = 1024;
   typedef struct packed {logic wr; logic [9:0] a; logic c;} item_t;
   typedef struct {bit armed, reading, reporting, pbad, mism, ok, sticky, fv; int nxt, errs, passes, first;} mdl_t;
   typedef struct {int corrupt, abort_at, skip_at, pcnt, ok, err, sticky, first, fv;} vec_t;
   logic clk = 0, rst = 1, wr_en = 1;
   logic [9:0] addr = '0;
   logic [7:0] rd1 = '0, ex1 = '0, rd3 = '0, ex3 = '0;
   logic ca1, mm1, pd1, po1, pa1, fs1, fv1, ca3, mm3, pd3, po3, pa3, fs3, fv3;
   logic [15:0] ec1, pc1;
   logic [2:0] ec3, pc3;
   logic [9:0] fa1, fa3;
   item_t hist [65536];
   mdl_t m [2];
   int lat [2] = '{1, 3};
   int cmax [2] = '{65535, 7};
   int pmod [2] = '{65536, 8};
   int n = 0, last_rst = -1, checks = 0, errors = 0, act_seen = 0;
   vec_t vecs [7];
   always #5 clk = ~clk;
   ram_readback_checker #(.LAT(1)) u1 (.clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .rd_data(rd1), .exp_data(ex1),
      .check_active(ca1), .mismatch(mm1), .pass_done(pd1), .pass_ok(po1), .pass_abort(pa1), .fail_sticky(fs1),
      .err_cnt(ec1), .pass_cnt(pc1), .first_err_addr(fa1), .first_err_valid(fv1));
   ram_readback_checker #(.LAT(3), .CNT_W(3)) u3 (.clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .rd_data(rd3), .exp_data(ex3),
      .check_active(ca3), .mismatch(mm3), .pass_done(pd3), .pass_ok(po3), .pass_abort(pa3), .fail_sticky(fs3),
      .err_cnt(ec3), .pass_cnt(pc3), .first_err_addr(fa3), .first_err_valid(fv3));
   function automatic logic [48:0] got_outs(input int k);
      return k == 0 ? {ca1, mm1, pd1, po1, pa1, fs1, fv1, fa1, ec1, pc1}
                    : {ca3, mm3, pd3, po3, pa3, fs3, fv3, fa3, 16'(ec3), 16'(pc3)};
   endfunction
   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s step %0d got %0d want %0d", name, n, got, want);
      end
   endtask
   task automatic check_dut(input int k, input logic r);
      item_t it;
      bit v, act, abt, bad;
      logic [48:0] want, got;
      v = (n - lat[k] >= 0) && (n - lat[k] > last_rst);
      it = v ? hist[n - lat[k]] : '0;
      act = v && !it.wr && m[k].armed;
      abt = v && it.wr && m[k].reading;
      want = {act, m[k].mism, m[k].reporting, m[k].ok, abt, m[k].sticky, m[k].fv, m[k].first[9:0], m[k].errs[15:0], m[k].passes[15:0]};
      got = got_outs(k);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL outs dut%0d step %0d got %h want %h", k, n, got, want);
      end
      bad = act && (it.c || (m[k].reading && int'(it.a) != m[k].nxt));
      if (r) m[k] = '{default: 0};
      else begin
         m[k].mism = bad;
         if (bad) begin
            if (m[k].errs < cmax[k]) m[k].errs++;
            m[k].sticky = 1;
            if (!m[k].fv) begin
               m[k].fv = 1;
               m[k].first = int'(it.a);
            end
         end
         if (m[k].reporting) begin
            m[k].reporting = 0;
            m[k].armed = v && it.wr;
         end else if (!m[k].armed) m[k].armed = v && it.wr && it.a == 0;
         else if (abt) m[k].reading = 0;
         else if (act) begin
            m[k].pbad = (m[k].reading && m[k].pbad) || bad;
            m[k].reading = 1;
            m[k].nxt = (int'(it.a) + 1) % DEPTH;
            if (it.a == DEPTH - 1) begin
               m[k].passes = (m[k].passes + 1) % pmod[k];
               m[k].ok = !m[k].pbad;
               m[k].reporting = 1;
               m[k].armed = 0;
               m[k].reading = 0;
            end
         end
      end
   endtask
   task automatic step(input logic w, input int a, input logic c, input logic r);
      item_t it;
      @(negedge clk);
      wr_en = w;
      addr = a[9:0];
      rst = r;
      hist[n] = '{w, a[9:0], c};
      for (int k = 0; k < 2; k++) begin
         it = n - lat[k] >= 0 ? hist[n - lat[k]] : '0;
         if (k == 0) begin
            ex1 = it.c ? 8'h3C : it.a[7:0];
            rd1 = it.c ? 8'hFF : it.a[7:0];
         end else begin
            ex3 = it.c ? 8'h3C : it.a[7:0];
            rd3 = it.c ? 8'hFF : it.a[7:0];
         end
      end
      #1;
      check_dut(0, r);
      check_dut(1, r);
      act_seen += int'(ca1) + int'(ca3);
      if (r) last_rst = n;
      n++;
   endtask
   task automatic run_pass(input int corrupt, input int abort_at, input int skip_at, input bit rnd);
      for (int a = 0; a < DEPTH; a++) step(1, a, 0, 0);
      for (int a = 0; a < DEPTH; a++) begin
         if (a == abort_at) break;
         if (skip_at >= 0 && a == skip_at + 1) continue;
         step(0, a, a == corrupt || (rnd && $urandom_range(63) == 0), 0);
      end
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
   endtask
   initial begin
      vecs[0] = '{-1, -1, -1, 1, 1, 0, 0, 0, 0};
      vecs[1] = '{-1, -1, -1, 2, 1, 0, 0, 0, 0};
      vecs[2] = '{517, -1, -1, 3, 0, 1, 1, 517, 1};
      vecs[3] = '{-1, -1, -1, 4, 1, 1, 1, 517, 1};
      vecs[4] = '{-1, 300, -1, 4, 1, 1, 1, 517, 1};
      vecs[5] = '{-1, -1, -1, 5, 1, 1, 1, 517, 1};
      vecs[6] = '{-1, -1, 100, 6, 0, 2, 1, 517, 1};
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
      chk("reset_outs1", int'(got_outs(0) == '0), 1);
      chk("reset_outs3", int'(got_outs(1) == '0), 1);
      for (int i = 0; i < 7; i++) begin
         run_pass(vecs[i].corrupt, vecs[i].abort_at, vecs[i].skip_at, 0);
         chk($sformatf("tbl%0d_pass_cnt", i), int'(pc1), vecs[i].pcnt);
         chk($sformatf("tbl%0d_pass_ok", i), int'(po1), vecs[i].ok);
         chk($sformatf("tbl%0d_err_cnt", i), int'(ec1), vecs[i].err);
         chk($sformatf("tbl%0d_fail_sticky", i), int'(fs1), vecs[i].sticky);
         chk($sformatf("tbl%0d_first_err", i), int'(fa1), vecs[i].first);
         chk($sformatf("tbl%0d_first_valid", i), int'(fv1), vecs[i].fv);
      end
      for (int a = 0; a < DEPTH; a++) step(1, a, 0, 0);
      for (int a = 0; a < 400; a++) step(0, a, a >= 10 && a < 15, 0);
      chk("pre_reset_err", int'(ec1), 7);
      step(0, 400, 0, 1);
      step(0, 401, 0, 1);
      chk("mid_reset_outs1", int'(got_outs(0) == '0), 1);
      chk("mid_reset_outs3", int'(got_outs(1) == '0), 1);
      for (int a = 402; a < 700; a++) step(0, a, 0, 1);
      act_seen = 0;
      for (int a = 700; a < DEPTH; a++) step(0, a, 0, 0);
      chk("startup_no_compare", act_seen, 0);
      chk("startup_no_pass", int'(pc1), 0);
      run_pass(-1, -1, -1, 0);
      chk("startup_pass_cnt", int'(pc1), 1);
      chk("startup_pass_ok", int'(po1), 1);
      chk("startup_err_cnt", int'(ec1), 0);
      for (int i = 0; i < 6; i++)
         run_pass(-1, $urandom_range(3) == 0 ? int'($urandom_range(1, DEPTH - 2)) : -1,
                  $urandom_range(3) == 0 ? int'($urandom_range(1, DEPTH - 3)) : -1, 1);
      chk("rand_sat3", int'(ec3), m[1].errs);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
